// File: rtl/axi_lite_reg_pkg.sv
// Shared definitions for the AXI-Lite register bridge: response codes and
// the transaction FSM state encoding.
package axi_lite_reg_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_USER = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_USER = 3'd3,
    ST_RD_RESP = 3'd4
  } state_t;

endpackage

// File: rtl/axi_lite_reg_bridge.sv
// AXI-Lite slave that hands one transaction at a time to a simple user
// register interface, using strobes for completion and an error flag.
module axi_lite_reg_bridge
  import axi_lite_reg_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_awvalid,
  input  logic [ADDR_WIDTH-1:0] i_awaddr,
  output logic                  o_awready,
  input  logic                  i_wvalid,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_wready,
  output logic                  o_bvalid,
  input  logic                  i_bready,
  output logic [1:0]            o_bresp,
  input  logic                  i_arvalid,
  input  logic [ADDR_WIDTH-1:0] i_araddr,
  output logic                  o_arready,
  output logic                  o_rvalid,
  input  logic                  i_rready,
  output logic [1:0]            o_rresp,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic [ADDR_WIDTH-1:0] o_reg_address,
  input  logic                  i_reg_invalid_addr,
  output logic                  o_reg_in_rdy,
  input  logic                  i_reg_in_ack_stb,
  output logic [DATA_WIDTH-1:0] o_reg_in_data,
  output logic                  o_reg_out_req,
  input  logic                  i_reg_out_rdy_stb,
  input  logic [DATA_WIDTH-1:0] i_reg_out_data
);

  state_t state_q, state_d;
  logic   idle;
  logic   wr_take;
  logic   rd_take;

  // Writes need both address and data; a concurrent read is held off.
  assign idle    = (state_q == ST_IDLE);
  assign wr_take = idle && i_awvalid && i_wvalid;
  assign rd_take = idle && i_arvalid && !(i_awvalid && i_wvalid);

  assign o_awready     = wr_take;
  assign o_wready      = wr_take;
  assign o_arready     = rd_take;
  assign o_reg_in_rdy  = (state_q == ST_WR_USER);
  assign o_bvalid      = (state_q == ST_WR_RESP);
  assign o_reg_out_req = (state_q == ST_RD_USER);
  assign o_rvalid      = (state_q == ST_RD_RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_take)      state_d = ST_WR_USER;
        else if (rd_take) state_d = ST_RD_USER;
      end
      ST_WR_USER: if (i_reg_in_ack_stb)  state_d = ST_WR_RESP;
      ST_WR_RESP: if (i_bready)          state_d = ST_IDLE;
      ST_RD_USER: if (i_reg_out_rdy_stb) state_d = ST_RD_RESP;
      ST_RD_RESP: if (i_rready)          state_d = ST_IDLE;
      default:                           state_d = ST_IDLE;
    endcase
  end

  // Payload and response registers only move on the handshake that owns them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_reg_address <= '0;
      o_reg_in_data <= '0;
      o_rdata       <= '0;
      o_bresp       <= RESP_OKAY;
      o_rresp       <= RESP_OKAY;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (wr_take) begin
            o_reg_address <= i_awaddr;
            o_reg_in_data <= i_wdata;
          end else if (rd_take) begin
            o_reg_address <= i_araddr;
          end
        end
        ST_WR_USER: begin
          if (i_reg_in_ack_stb)
            o_bresp <= i_reg_invalid_addr ? RESP_SLVERR : RESP_OKAY;
        end
        ST_RD_USER: begin
          if (i_reg_out_rdy_stb) begin
            o_rdata <= i_reg_out_data;
            o_rresp <= i_reg_invalid_addr ? RESP_SLVERR : RESP_OKAY;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_bridge.sv
// Bench for axi_lite_reg_bridge: a transaction-level expectation model is
// updated by the driver tasks and compared against the DUT every cycle.
module tb_axi_lite_reg_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_awvalid, i_wvalid, i_bready, i_arvalid, i_rready;
  logic [15:0] i_awaddr, i_araddr;
  logic [31:0] i_wdata, i_reg_out_data;
  logic        i_reg_invalid_addr, i_reg_in_ack_stb, i_reg_out_rdy_stb;
  logic        o_awready, o_wready, o_bvalid, o_arready, o_rvalid;
  logic [1:0]  o_bresp, o_rresp;
  logic [31:0] o_rdata, o_reg_in_data;
  logic [15:0] o_reg_address;
  logic        o_reg_in_rdy, o_reg_out_req;

  // Expected-behaviour model: what the bridge owes the bus and the user.
  logic [15:0] m_addr;
  logic [31:0] m_wdata, m_rdata;
  logic [1:0]  m_bresp, m_rresp;
  logic        m_in_rdy, m_out_req, m_bvalid, m_rvalid, m_idle;

  int n_checks = 0;
  int n_fail   = 0;

  axi_lite_reg_bridge #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .i_awvalid(i_awvalid), .i_awaddr(i_awaddr), .o_awready(o_awready),
    .i_wvalid(i_wvalid), .i_wdata(i_wdata), .o_wready(o_wready),
    .o_bvalid(o_bvalid), .i_bready(i_bready), .o_bresp(o_bresp),
    .i_arvalid(i_arvalid), .i_araddr(i_araddr), .o_arready(o_arready),
    .o_rvalid(o_rvalid), .i_rready(i_rready), .o_rresp(o_rresp), .o_rdata(o_rdata),
    .o_reg_address(o_reg_address), .i_reg_invalid_addr(i_reg_invalid_addr),
    .o_reg_in_rdy(o_reg_in_rdy), .i_reg_in_ack_stb(i_reg_in_ack_stb),
    .o_reg_in_data(o_reg_in_data), .o_reg_out_req(o_reg_out_req),
    .i_reg_out_rdy_stb(i_reg_out_rdy_stb), .i_reg_out_data(i_reg_out_data)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every negedge the DUT must match the model.
  always @(negedge clk) begin
    m_idle = !(m_in_rdy || m_out_req || m_bvalid || m_rvalid);
    checkOutput("awready",  64'(o_awready),  64'(m_idle && i_awvalid && i_wvalid));
    checkOutput("wready",   64'(o_wready),   64'(m_idle && i_awvalid && i_wvalid));
    checkOutput("arready",  64'(o_arready),  64'(m_idle && i_arvalid && !(i_awvalid && i_wvalid)));
    checkOutput("bvalid",   64'(o_bvalid),   64'(m_bvalid));
    checkOutput("rvalid",   64'(o_rvalid),   64'(m_rvalid));
    checkOutput("in_rdy",   64'(o_reg_in_rdy),  64'(m_in_rdy));
    checkOutput("out_req",  64'(o_reg_out_req), 64'(m_out_req));
    checkOutput("bresp",    64'(o_bresp),    64'(m_bresp));
    checkOutput("rresp",    64'(o_rresp),    64'(m_rresp));
    checkOutput("rdata",    64'(o_rdata),    64'(m_rdata));
    checkOutput("address",  64'(o_reg_address), 64'(m_addr));
    checkOutput("in_data",  64'(o_reg_in_data), 64'(m_wdata));
  end

  task automatic model_reset();
    m_addr = '0; m_wdata = '0; m_rdata = '0; m_bresp = 2'b00; m_rresp = 2'b00;
    m_in_rdy = 0; m_out_req = 0; m_bvalid = 0; m_rvalid = 0;
  endtask

  task automatic clear_inputs();
    i_awvalid = 0; i_wvalid = 0; i_bready = 0; i_arvalid = 0; i_rready = 0;
    i_awaddr = '0; i_araddr = '0; i_wdata = '0; i_reg_out_data = '0;
    i_reg_invalid_addr = 0; i_reg_in_ack_stb = 0; i_reg_out_rdy_stb = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_accept(input logic [15:0] a, input logic [31:0] d);
    i_awvalid = 1; i_wvalid = 1; i_awaddr = a; i_wdata = d;
    step();
    i_awvalid = 0; i_wvalid = 0;
    m_addr = a; m_wdata = d; m_in_rdy = 1;
  endtask

  task automatic rd_accept(input logic [15:0] a);
    i_arvalid = 1; i_araddr = a;
    step();
    i_arvalid = 0;
    m_addr = a; m_out_req = 1;
  endtask

  // User side stalls; the strobe belonging to the other direction is noise.
  task automatic user_wait(input int n);
    repeat (n) begin
      i_reg_invalid_addr = 1'($urandom);
      i_reg_out_data = $urandom;
      if (m_in_rdy) i_reg_out_rdy_stb = 1'($urandom);
      else          i_reg_in_ack_stb  = 1'($urandom);
      step();
    end
    i_reg_out_rdy_stb = 0; i_reg_in_ack_stb = 0;
  endtask

  task automatic wr_ack(input logic inv);
    i_reg_in_ack_stb = 1; i_reg_invalid_addr = inv;
    step();
    i_reg_in_ack_stb = 0;
    m_in_rdy = 0; m_bvalid = 1; m_bresp = inv ? 2'b10 : 2'b00;
  endtask

  task automatic rd_ack(input logic [31:0] d, input logic inv);
    i_reg_out_rdy_stb = 1; i_reg_out_data = d; i_reg_invalid_addr = inv;
    step();
    i_reg_out_rdy_stb = 0;
    m_out_req = 0; m_rvalid = 1; m_rdata = d; m_rresp = inv ? 2'b10 : 2'b00;
  endtask

  // Master stalls the response; stray strobes and new requests must be ignored.
  task automatic resp_wait(input int n, input bit junk);
    repeat (n) begin
      i_reg_in_ack_stb = 1'($urandom); i_reg_out_rdy_stb = 1'($urandom);
      i_reg_invalid_addr = 1'($urandom); i_reg_out_data = $urandom;
      if (junk) begin
        i_awvalid = 1; i_wvalid = 1; i_arvalid = 1;
        i_awaddr = 16'($urandom); i_araddr = 16'($urandom); i_wdata = $urandom;
      end
      step();
    end
    i_reg_in_ack_stb = 0; i_reg_out_rdy_stb = 0;
    if (junk) begin
      i_awvalid = 0; i_wvalid = 0; i_arvalid = 0;
    end
  endtask

  task automatic wr_finish();
    i_bready = 1;
    step();
    i_bready = 0;
    m_bvalid = 0;
  endtask

  task automatic rd_finish();
    i_rready = 1;
    step();
    i_rready = 0;
    m_rvalid = 0;
  endtask

  // One randomized transaction with random stalls on both sides.
  task automatic applyStimulus();
    logic [15:0] a;
    logic [31:0] d;
    logic        inv;
    a = 16'($urandom); d = $urandom; inv = 1'($urandom);
    if ($urandom_range(0, 1) == 1) begin
      wr_accept(a, d);
      user_wait($urandom_range(0, 3));
      wr_ack(inv);
      resp_wait($urandom_range(0, 3), 1'($urandom));
      wr_finish();
    end else begin
      rd_accept(a);
      user_wait($urandom_range(0, 3));
      rd_ack(d, inv);
      resp_wait($urandom_range(0, 3), 1'($urandom));
      rd_finish();
    end
  endtask

  initial begin
    clear_inputs();
    model_reset();
    rst = 1;
    step();
    step();
    rst = 0;

    // Plain write
    wr_accept(16'h0000, 32'hDEADBEEF);
    user_wait(1);
    wr_ack(0);
    checkOutput("lit_wr_bvalid", 64'(o_bvalid), 64'h1);
    checkOutput("lit_wr_bresp", 64'(o_bresp), 64'h0);
    checkOutput("lit_wr_data", 64'(o_reg_in_data), 64'hDEADBEEF);
    checkOutput("lit_wr_addr", 64'(o_reg_address), 64'h0);
    wr_finish();

    // Plain read
    rd_accept(16'h0004);
    user_wait(2);
    rd_ack(32'h10000000, 0);
    checkOutput("lit_rd_rvalid", 64'(o_rvalid), 64'h1);
    checkOutput("lit_rd_rdata", 64'(o_rdata), 64'h10000000);
    checkOutput("lit_rd_rresp", 64'(o_rresp), 64'h0);
    rd_finish();

    // Invalid address on read and write
    rd_accept(16'h0008);
    rd_ack(32'h0, 1);
    checkOutput("lit_rd_slverr", 64'(o_rresp), 64'h2);
    rd_finish();
    wr_accept(16'h0008, 32'h12345678);
    wr_ack(1);
    checkOutput("lit_wr_slverr", 64'(o_bresp), 64'h2);
    wr_finish();

    // Write and read presented together: write goes first
    i_arvalid = 1; i_araddr = 16'h000C;
    wr_accept(16'h0010, 32'hCAFEF00D);
    wr_ack(0);
    checkOutput("lit_race_bvalid", 64'(o_bvalid), 64'h1);
    checkOutput("lit_race_addr", 64'(o_reg_address), 64'h0010);
    wr_finish();
    rd_accept(16'h000C);
    checkOutput("lit_race_rd_addr", 64'(o_reg_address), 64'h000C);
    rd_ack(32'h55AA55AA, 0);
    rd_finish();

    // Response stalled five cycles with competing requests on the bus
    wr_accept(16'h0020, 32'h00000001);
    wr_ack(0);
    resp_wait(5, 1'b1);
    checkOutput("lit_stall_addr", 64'(o_reg_address), 64'h0020);
    checkOutput("lit_stall_bvalid", 64'(o_bvalid), 64'h1);
    wr_finish();

    // Reset while the user is serving a read
    rd_accept(16'h0030);
    user_wait(1);
    rst = 1;
    model_reset();
    clear_inputs();
    #1;
    checkOutput("lit_rst_out_req", 64'(o_reg_out_req), 64'h0);
    checkOutput("lit_rst_rvalid", 64'(o_rvalid), 64'h0);
    checkOutput("lit_rst_addr", 64'(o_reg_address), 64'h0);
    step();
    rst = 0;
    wr_accept(16'h0040, 32'hA5A5A5A5);
    wr_ack(0);
    checkOutput("lit_post_rst_bvalid", 64'(o_bvalid), 64'h1);
    wr_finish();

    repeat (150) applyStimulus();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
